adc_scan_sequencer: RTL and testbench

Round-robin multi-channel scan controller for the 8-channel SPI ADC (LTC2308-style, 6-bit config word in, 12-bit result out) on the 1 MHz ADC clock domain. Each frame it generates the CONVST pulse, the gated serial clock, the channel config word on SDI, and captures SDO. Enabled channels are converted in round-robin order. Tagged results go to downstream logic through a one-entry valid/ready holding register.

---
 rtl/adc_seq_pkg.sv | 39 +++
 rtl/adc_frame_timer.sv | 62 ++++++
 rtl/adc_scan_sequencer.sv | 136 +++++++++++++
 tb/tb_adc_scan_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// Shared widths, config-word bit map and result record for the ADC scan sequencer.
// Pure definitions: no latency, no flow control.
package adc_seq_pkg;

  localparam int CFG_BITS = 6;
  localparam int RES_BITS = 12;
  localparam int NUM_CH   = 8;
  localparam int CH_BITS  = $clog2(NUM_CH);

  // Bit positions within the config word; the MSB goes out on SDI first.
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  typedef logic [CFG_BITS-1:0] cfg_word_t;
  typedef logic [CH_BITS-1:0]  chan_t;
  typedef logic [RES_BITS-1:0] res_t;

  typedef struct packed {
    chan_t channel;
    res_t  data;
  } result_t;

  function automatic cfg_word_t chan_to_cfg(input chan_t ch, input logic uni);
    cfg_word_t w;
    w          = '0;
    w[CFG_SD]  = 1'b1;
    w[CFG_OS]  = ch[0];
    w[CFG_S1]  = ch[2];
    w[CFG_S0]  = ch[1];
    w[CFG_UNI] = uni;
    w[CFG_SLP] = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/adc_frame_timer.sv
// Frame counter plus falling-edge CONVST/SCK-gate/SDI registers; outputs change half a clk after the enables.
// No backpressure: the frame runs continuously, enables only gate what is driven to the ADC.
module adc_frame_timer
  import adc_seq_pkg::*;
#(
  parameter int  FRAME_LEN = 16,
  localparam int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             convst_en,
  input  logic             gate_en,
  input  logic             sdi_en,
  input  logic             sdi_bit,
  output logic [CNT_W-1:0] count,
  output logic             frame_wrap,
  output logic             sdi_slot,
  output logic             sdo_slot,
  output logic             adc_convst,
  output logic             adc_sck,
  output logic             adc_sdi
);

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] SLOT_START = CNT_W'(3);
  localparam logic [CNT_W-1:0] SDI_END    = CNT_W'(3 + CFG_BITS - 1);
  localparam logic [CNT_W-1:0] SDO_END    = CNT_W'(3 + RES_BITS - 1);

  logic convst_win;
  logic convst_q;
  logic gate_q;
  logic sdi_q;

  assign frame_wrap = (count == LAST_CNT);
  assign convst_win = (count == CNT_W'(1)) || (count == CNT_W'(2));
  assign sdi_slot   = (count >= SLOT_START) && (count <= SDI_END);
  assign sdo_slot   = (count >= SLOT_START) && (count <= SDO_END);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        count <= '0;
    else if (frame_wrap) count <= '0;
    else                 count <= count + 1'b1;
  end

  // Falling-edge registers keep SCK glitch-free and give SDI half a cycle of setup.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      convst_q <= 1'b0;
      gate_q   <= 1'b0;
      sdi_q    <= 1'b0;
    end else begin
      convst_q <= convst_en && convst_win;
      gate_q   <= gate_en && sdo_slot;
      sdi_q    <= sdi_en && sdi_slot && sdi_bit;
    end
  end

  assign adc_convst = convst_q;
  assign adc_sck    = gate_q & clk;
  assign adc_sdi    = sdi_q;

endmodule

// File: rtl/adc_scan_sequencer.sv
// Round-robin 8-channel SPI ADC scanner; a pick at frame N count 0 is held for output from frame N+2 count 0.
// One-entry valid/ready holding register: a result arriving while it is full and not being accepted is dropped and flagged.
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter bit UNIPOLAR  = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_mask,
  output logic                adc_convst,
  output logic                adc_sck,
  output logic                adc_sdi,
  input  logic                adc_sdo,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CH_BITS-1:0]  res_channel,
  output logic [RES_BITS-1:0] res_data,
  output logic                overrun,
  output logic                busy
);

  localparam int CNT_W = $clog2(FRAME_LEN);

  logic [CNT_W-1:0] count;
  logic             frame_wrap;
  logic             sdi_slot;
  logic             sdo_slot;

  logic      pick_vld;
  logic      pick_go;
  chan_t     pick_ch;
  chan_t     cand;
  chan_t     last_ch;
  logic      cfg_vld;
  chan_t     cfg_ch;
  cfg_word_t cfg_sr;
  logic      rd_vld;
  chan_t     rd_ch;
  res_t      sdo_sr;
  result_t   hold;
  logic      hold_vld;
  logic      ovr_q;
  logic      hs;
  logic      publish;

  adc_frame_timer #(.FRAME_LEN(FRAME_LEN)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .convst_en  (rd_vld),
    .gate_en    (cfg_vld | rd_vld),
    .sdi_en     (cfg_vld),
    .sdi_bit    (cfg_sr[CFG_BITS-1]),
    .count      (count),
    .frame_wrap (frame_wrap),
    .sdi_slot   (sdi_slot),
    .sdo_slot   (sdo_slot),
    .adc_convst (adc_convst),
    .adc_sck    (adc_sck),
    .adc_sdi    (adc_sdi)
  );

  // Walk offsets from farthest to nearest so the nearest set bit after last_ch wins;
  // offset NUM_CH lands back on last_ch itself, covering a single-bit mask.
  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = last_ch;
    cand     = last_ch;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = last_ch + chan_t'(i);
      if (ch_mask[cand]) begin
        pick_vld = 1'b1;
        pick_ch  = cand;
      end
    end
  end

  assign pick_go = (count == '0) && enable && pick_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_ch <= chan_t'(NUM_CH - 1);
      cfg_vld <= 1'b0;
      cfg_ch  <= '0;
      cfg_sr  <= '0;
      rd_vld  <= 1'b0;
      rd_ch   <= '0;
      sdo_sr  <= '0;
    end else begin
      if (frame_wrap) begin
        rd_vld  <= cfg_vld;
        rd_ch   <= cfg_ch;
        cfg_vld <= 1'b0;
      end else if (pick_go) begin
        cfg_vld <= 1'b1;
        cfg_ch  <= pick_ch;
        last_ch <= pick_ch;
        cfg_sr  <= chan_to_cfg(pick_ch, UNIPOLAR);
      end else if (cfg_vld && sdi_slot) begin
        cfg_sr  <= cfg_sr << 1;
      end
      if (rd_vld && sdo_slot)
        sdo_sr <= {sdo_sr[RES_BITS-2:0], adc_sdo};
    end
  end

  assign hs      = hold_vld && res_ready;
  assign publish = frame_wrap && rd_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_vld <= 1'b0;
      hold     <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (publish && (!hold_vld || hs)) begin
        hold_vld     <= 1'b1;
        hold.channel <= rd_ch;
        hold.data    <= sdo_sr;
      end else if (hs) begin
        hold_vld <= 1'b0;
      end
      if (publish && hold_vld && !hs) ovr_q <= 1'b1;
      else if (hs)                    ovr_q <= 1'b0;
    end
  end

  assign res_valid   = hold_vld;
  assign res_channel = hold.channel;
  assign res_data    = hold.data;
  assign overrun     = ovr_q;
  assign busy        = cfg_vld | rd_vld | hold_vld;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: behavioural ADC on the serial pins plus a frame-level scoreboard of expected results.
`timescale 1ns/1ps
module tb_adc_scan_sequencer;

  localparam int FL = 16;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b1;
  logic        enable    = 1'b0;
  logic [7:0]  ch_mask   = 8'h00;
  logic        res_ready = 1'b0;
  logic        adc_sdo   = 1'b0;
  logic        adc_convst, adc_sck, adc_sdi;
  logic        res_valid, overrun, busy;
  logic [2:0]  res_channel;
  logic [11:0] res_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  adc_scan_sequencer #(.FRAME_LEN(FL), .UNIPOLAR(1'b1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .ch_mask     (ch_mask),
    .adc_convst  (adc_convst),
    .adc_sck     (adc_sck),
    .adc_sdi     (adc_sdi),
    .adc_sdo     (adc_sdo),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_channel (res_channel),
    .res_data    (res_data),
    .overrun     (overrun),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Conversion value the ADC returns per channel.
  function automatic logic [11:0] res_of(input logic [2:0] ch);
    return (ch == 3'd0) ? 12'hA5C : 12'h3C3 + 12'h1A1 * {9'd0, ch};
  endfunction

  // Decode a config word as the ADC would: S/D, O/S=ch0, S1=ch2, S0=ch1, UNI, SLP.
  function automatic logic [11:0] data_for(input logic [5:0] w);
    logic [2:0] ch;
    ch = {w[3], w[2], w[4]};
    if (w[5] && w[1] && !w[0]) return res_of(ch);
    return 12'hFFF;
  endfunction

  // ---------------- behavioural ADC ----------------
  int         sck_edges    = 0;
  int         convst_edges = 0;
  int         burst_idx    = 0;
  logic [5:0] cfg_in  = '0;
  logic [5:0] adc_cfg = '0;
  logic [11:0] sdo_sh = '0;

  always @(posedge adc_sck or negedge reset_n) begin
    if (!reset_n) begin
      burst_idx = 0;
    end else begin
      sck_edges++;
      if (burst_idx < 6) cfg_in = {cfg_in[4:0], adc_sdi};
      if (burst_idx == 5) adc_cfg = cfg_in;
      burst_idx = (burst_idx + 1) % 12;
    end
  end

  always @(posedge adc_convst or negedge adc_sck) begin
    if (adc_convst) begin
      convst_edges++;
      sdo_sh = data_for(adc_cfg);
    end else begin
      sdo_sh = sdo_sh << 1;
    end
    adc_sdo = sdo_sh[11];
  end

  // ---------------- frame-level model and scoreboard ----------------
  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] dat;
  } exp_t;

  exp_t       sb_q[$];
  int         tb_cnt   = 0;
  int         sck_base = 0;
  int         cst_base = 0;
  bit         m_cfg_vld, m_rd_vld, m_full, m_ovr;
  logic [2:0] m_last = 3'd7;

  // Called mid-cycle with inputs already set for the coming rising edge.
  task automatic tick();
    bit         hs;
    bit         picked;
    logic [2:0] pc;
    exp_t       e;
    if (tb_cnt == 0) begin
      check("res_valid", res_valid, m_full);
      check("overrun", overrun, m_ovr);
      if (m_full) begin
        check("held_ch", res_channel, sb_q[0].ch);
        check("held_dat", res_data, sb_q[0].dat);
      end
    end
    if (tb_cnt == 1)  check("busy", busy, m_cfg_vld | m_rd_vld | m_full);
    if (tb_cnt == 2)  check("convst_hi", adc_convst, m_rd_vld);
    if (tb_cnt == 4)  check("convst_lo", adc_convst, 0);
    if (tb_cnt == 10) check("sdi_idle", adc_sdi, 0);
    if (tb_cnt == FL-1) begin
      check("sck_edges", sck_edges - sck_base, (m_cfg_vld | m_rd_vld) ? 12 : 0);
      check("convst_edges", convst_edges - cst_base, m_rd_vld ? 1 : 0);
      sck_base = sck_edges;
      cst_base = convst_edges;
    end

    hs = m_full && res_ready;
    if (hs) begin
      check("hs_valid", res_valid, 1);
      e = sb_q.pop_front();
      check("hs_ch", res_channel, e.ch);
      check("hs_dat", res_data, e.dat);
      m_full = 0;
      m_ovr  = 0;
    end
    if (tb_cnt == 0 && enable) begin
      picked = 0;
      pc     = m_last;
      for (int i = 1; i <= 8 && !picked; i++) begin
        pc = m_last + 3'(i);
        if (ch_mask[pc]) picked = 1;
      end
      if (picked) begin
        m_last    = pc;
        m_cfg_vld = 1;
        sb_q.push_back('{ch: pc, dat: res_of(pc)});
      end
    end
    if (tb_cnt == FL-1) begin
      if (m_rd_vld) begin
        if (!m_full) m_full = 1;
        else begin
          sb_q.delete(sb_q.size() - 1 - (m_cfg_vld ? 1 : 0));
          m_ovr = 1;
        end
      end
      m_rd_vld  = m_cfg_vld;
      m_cfg_vld = 0;
    end
    @(posedge clk);
    #1;
    tb_cnt = (tb_cnt == FL-1) ? 0 : tb_cnt + 1;
  endtask

  task automatic run_frames(input int n);
    repeat (n * FL) tick();
  endtask

  task automatic run_to(input int c);
    while (tb_cnt != c) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_convst", adc_convst, 0);
    check("rst_sck", adc_sck, 0);
    check("rst_sdi", adc_sdi, 0);
    check("rst_valid", res_valid, 0);
    check("rst_channel", res_channel, 0);
    check("rst_data", res_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    m_cfg_vld = 0;
    m_rd_vld  = 0;
    m_full    = 0;
    m_ovr     = 0;
    m_last    = 3'd7;
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    tb_cnt   = 0;
    sck_base = sck_edges;
    cst_base = convst_edges;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    #2;
    do_reset();

    // Alternating two-channel scan, free-flowing output.
    enable = 1'b1; ch_mask = 8'h05; res_ready = 1'b1;
    run_frames(6);

    // Empty mask: in-flight work drains, then the bus stays idle.
    run_to(1);
    ch_mask = 8'h00;
    run_frames(4);

    // Full scan against a stalled consumer, then a single acceptance.
    ch_mask = 8'hFF; res_ready = 1'b0;
    run_frames(4);
    run_to(6);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    run_to(0);

    // Acceptance on the very edge a new result is published into a full register.
    run_to(FL-1);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    run_frames(1);
    res_ready = 1'b1;
    run_frames(2);

    // Disable right after a ch3 pick: that conversion still drains.
    ch_mask = 8'h08;
    run_to(0);
    tick();
    enable = 1'b0;
    run_frames(5);

    // Reset in the middle of a result shift.
    enable = 1'b1; ch_mask = 8'h06;
    run_frames(2);
    run_to(9);
    do_reset();
    run_frames(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
